fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control sequencer for the instruction-fetch stage. Each cycle it drives the three fetch-stage mux selects: PC source, IR2 source and PC2 load/hold. The selects are driven from a small state machine plus halt, redirect and stall requests from the later pipeline stages. It sits beside the fetch datapath and is the only block that drives `selectmux0`, `selectmux1` and `selectmux2`.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: total NOP bubbles injected into IR2 per redirect, including the redirect cycle. Legal range is 1..15.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `start`: input, 1 bit. Leave IDLE/HALT and begin fetching.
- `halt`: input, 1 bit. Freeze fetch and enter HALT.
- `branch_taken`: input, 1 bit. Redirect to the branch target (`pc_sel`=3).
- `jump`: input, 1 bit. Redirect to the jump target z4 (`pc_sel`=0).
- `stall`: input, 1 bit. Hazard hold request.
- `pc_sel`: output, 2 bits. PC mux select: 0=z4, 1=pc+4, 2=hold, 3=branch target.
- `ir_sel`: output, 2 bits. IR2 mux select: 0=instruction memory, 1=NOP, 2=hold.
- `pc2_sel`: output, 1 bit. PC2 mux select: 0=load pc+4, 1=hold.
- `bubble`: output, 1 bit. High whenever `ir_sel`=1.
- `state_o`: output, 2 bits. Current state: 0=IDLE, 1=RUN, 2=FLUSH, 3=HALT.
- `stall_count`: output, `CNT_W` bits. Present only when `FETCH_PERF_CNT_EN` is defined.
- `bubble_count`: output, `CNT_W` bits. Present only when `FETCH_PERF_CNT_EN` is defined.

## Operation
- The state and flush counter are registered. Outputs are combinational from the current state and current inputs, so a request acts at the same clock edge that captures the fetch registers.
- Priority in every non-IDLE state: `halt` > `branch_taken` > `jump` > `stall` > normal.
- IDLE:
  - Outputs are `pc_sel`=2, `ir_sel`=1, `pc2_sel`=1.
  - `start` moves the state to RUN. All other inputs are ignored.
- HALT:
  - Outputs are the same as IDLE.
  - `start` moves the state to RUN.
  - `branch_taken`, `jump` and `stall` are ignored.
- RUN:
  - Normal: `pc_sel`=1, `ir_sel`=0, `pc2_sel`=0.
  - Stall: `pc_sel`=2, `ir_sel`=2, `pc2_sel`=1. State stays RUN.
  - Redirect: `pc_sel`=3 for branch or 0 for jump, with `ir_sel`=1 and `pc2_sel`=1.
    - If `FLUSH_CYCLES`=1, the state stays RUN.
    - Otherwise the state goes to FLUSH and `fcnt` loads `FLUSH_CYCLES`-1.
  - `halt` moves the state to HALT with the IDLE outputs.
- FLUSH:
  - Normal: `pc_sel`=1, `ir_sel`=1, `pc2_sel`=0. `fcnt` decrements; at `fcnt`=1 the next state is RUN.
  - Stall: `pc_sel`=2, `ir_sel`=1, `pc2_sel`=1. `fcnt` is held.
  - A new redirect applies the redirect outputs and reloads `fcnt` to `FLUSH_CYCLES`-1. Newest redirect wins.
  - `halt` moves the state to HALT and clears `fcnt`.
- `start` is ignored while in RUN or FLUSH.
- `fcnt` is 4 bits wide and never wraps below 1 while in FLUSH.

## Timing
- Reset (async assert, sync deassert as seen by the FSM): state=IDLE, `fcnt`=0, perf counters=0.
  - Outputs during reset are therefore `pc_sel`=2, `ir_sel`=1, `pc2_sel`=1, `bubble`=1, `state_o`=0.
- First useful fetch: one cycle after the `start` edge.
- Redirect-to-valid IR2: exactly `FLUSH_CYCLES` bubble cycles, excluding stalled cycles.
- Reset asserted mid-FLUSH aborts immediately to IDLE. No bubble debt survives reset.
- Simultaneous `branch_taken` and `jump`: the branch wins and `jump` is dropped; the requester must re-present it.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `stall_count` increments on every cycle with `pc_sel`=2 while in RUN or FLUSH.
  - `bubble_count` increments on every cycle with `bubble`=1 while in RUN or FLUSH.
  - Both counters saturate at all-ones and clear only on reset.
- `FETCH_PERF_CNT_EN` undefined: both ports and all counter logic are absent; behaviour is otherwise identical.

## Structure
- The shared package `fetch_pkg` holds:
  - the `pc_sel` encodings: `PC_Z4`, `PC_INC`, `PC_HOLD`, `PC_BR`;
  - the `ir_sel` encodings: `IR_MEM`, `IR_NOP`, `IR_HOLD`;
  - the `pc2_sel` encodings: `PC2_LOAD`, `PC2_HOLD`;
  - the state enum: `FS_IDLE`, `FS_RUN`, `FS_FLUSH`, `FS_HALT`.
- One sub-module, `sat_counter`, is a parameterised saturating incrementer, instantiated twice under the macro.

## Test plan
- Reset, then `start` pulse, then 5 free cycles:
  - During reset: selects 2/1/1 and `state_o`=0.
  - From cycle 1 after `start`: selects 1/0/0 with `state_o`=1.
- `branch_taken` for one cycle in RUN, `FLUSH_CYCLES`=2:
  - Cycle 0: 3/1/1.
  - Cycle 1: 1/1/0 with `state_o`=2.
  - Cycle 2: 1/0/0 with `state_o`=1.
- `jump` during FLUSH with `stall` on the following 2 cycles:
  - Jump cycle: 0/1/1.
  - Stall cycles: 2/1/1 with `fcnt` held at 1.
  - Then one 1/1/0 cycle, then RUN.
- `branch_taken`, `jump` and `stall` all asserted together: output 3/1/1; the jump is lost.
- `halt` during FLUSH:
  - Next state HALT with 2/1/1.
  - `start` returns the state to RUN and produces no leftover bubbles.
- With `FETCH_PERF_CNT_EN` defined and `CNT_W`=4: 20 stall cycles give `stall_count`=15 (saturated). Reset clears it to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - mux select encodings, state enum and widths shared by the fetch sequencer
package fetch_pkg;

    localparam logic [1:0] PC_Z4   = 2'd0;
    localparam logic [1:0] PC_INC  = 2'd1;
    localparam logic [1:0] PC_HOLD = 2'd2;
    localparam logic [1:0] PC_BR   = 2'd3;

    localparam logic [1:0] IR_MEM  = 2'd0;
    localparam logic [1:0] IR_NOP  = 2'd1;
    localparam logic [1:0] IR_HOLD = 2'd2;

    localparam logic PC2_LOAD = 1'b0;
    localparam logic PC2_HOLD = 1'b1;

    localparam int FCNT_W = 4;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_RUN   = 2'd1,
        FS_FLUSH = 2'd2,
        FS_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit incrementer that sticks at all-ones, cleared only by reset
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch-stage mux select sequencer (IDLE/RUN/FLUSH/HALT)
// Optional stall/bubble performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             stall,
    output logic [1:0]       pc_sel,
    output logic [1:0]       ir_sel,
    output logic             pc2_sel,
    output logic             bubble,
    output logic [1:0]       state_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] bubble_count
`endif
);

    localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    fetch_state_e      w_redirect_state;
    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcnt_next;
    logic              w_redirect;
    logic [1:0]        w_redirect_pc;

    // Branch outranks jump when both arrive together; the jump is simply dropped.
    assign w_redirect       = branch_taken | jump;
    assign w_redirect_pc    = branch_taken ? PC_BR : PC_Z4;
    assign w_redirect_state = (FLUSH_CYCLES == 1) ? FS_RUN : FS_FLUSH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FS_IDLE;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_fcnt  <= w_fcnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fcnt_next  = r_fcnt;
        pc_sel       = PC_HOLD;
        ir_sel       = IR_NOP;
        pc2_sel      = PC2_HOLD;

        case (r_state)
            FS_IDLE: begin
                if (start) begin
                    w_state_next = FS_RUN;
                end
            end
            FS_HALT: begin
                if (!halt && start) begin
                    w_state_next = FS_RUN;
                end
            end
            FS_RUN: begin
                if (halt) begin
                    w_state_next = FS_HALT;
                end else if (w_redirect) begin
                    pc_sel       = w_redirect_pc;
                    w_state_next = w_redirect_state;
                    w_fcnt_next  = FCNT_RELOAD;
                end else if (stall) begin
                    ir_sel = IR_HOLD;
                end else begin
                    pc_sel  = PC_INC;
                    ir_sel  = IR_MEM;
                    pc2_sel = PC2_LOAD;
                end
            end
            FS_FLUSH: begin
                if (halt) begin
                    w_state_next = FS_HALT;
                    w_fcnt_next  = '0;
                end else if (w_redirect) begin
                    pc_sel       = w_redirect_pc;
                    w_state_next = w_redirect_state;
                    w_fcnt_next  = FCNT_RELOAD;
                end else if (!stall) begin
                    // PC advances while IR2 keeps receiving NOPs until the debt is paid.
                    pc_sel  = PC_INC;
                    pc2_sel = PC2_LOAD;
                    if (r_fcnt <= FCNT_W'(1)) begin
                        w_state_next = FS_RUN;
                        w_fcnt_next  = '0;
                    end else begin
                        w_fcnt_next = r_fcnt - FCNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = FS_IDLE;
                w_fcnt_next  = '0;
            end
        endcase
    end

    assign bubble  = (ir_sel == IR_NOP);
    assign state_o = r_state;

`ifdef FETCH_PERF_CNT_EN
    logic w_active;

    assign w_active = (r_state == FS_RUN) || (r_state == FS_FLUSH);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_active && (pc_sel == PC_HOLD)),
        .o_count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_active && bubble),
        .o_count (bubble_count)
    );
`else
    if (CNT_W > 0) begin : g_no_perf_cnt
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - vector table, corner sequences and random run against a bubble-debt model
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic halt = 1'b0;
    logic branch_taken = 1'b0;
    logic jump = 1'b0;
    logic stall = 1'b0;

    logic [1:0] pc_sel_a, ir_sel_a, state_o_a;
    logic       pc2_sel_a, bubble_a;
    logic [1:0] pc_sel_b, ir_sel_b, state_o_b;
    logic       pc2_sel_b, bubble_b;
`ifdef FETCH_PERF_CNT_EN
    logic [3:0]  stall_count_a, bubble_count_a;
    logic [31:0] stall_count_b, bubble_count_b;
`endif

    always #5 clk = ~clk;

    fetch_sequencer #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .branch_taken(branch_taken), .jump(jump), .stall(stall),
        .pc_sel(pc_sel_a), .ir_sel(ir_sel_a), .pc2_sel(pc2_sel_a),
        .bubble(bubble_a), .state_o(state_o_a)
`ifdef FETCH_PERF_CNT_EN
        , .stall_count(stall_count_a), .bubble_count(bubble_count_a)
`endif
    );

    fetch_sequencer #(.FLUSH_CYCLES(3), .CNT_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .branch_taken(branch_taken), .jump(jump), .stall(stall),
        .pc_sel(pc_sel_b), .ir_sel(ir_sel_b), .pc2_sel(pc2_sel_b),
        .bubble(bubble_b), .state_o(state_o_b)
`ifdef FETCH_PERF_CNT_EN
        , .stall_count(stall_count_b), .bubble_count(bubble_count_b)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: a fetcher is idle, halted or active; while active it owes a number
    // of NOP bubbles still to be delivered after the current cycle.
    localparam int M_IDLE = 0, M_ACTIVE = 1, M_HALT = 2;
    int     flush_n[2] = '{2, 3};
    longint cnt_max[2] = '{64'd15, 64'hFFFF_FFFF};
    int     m_mode[2];
    int     m_debt[2];
    longint m_stc[2];
    longint m_bbc[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = M_IDLE;
            m_debt[d] = 0;
            m_stc[d]  = 0;
            m_bbc[d]  = 0;
        end
    endtask

    task automatic model_eval(input int d, output logic [1:0] pc, output logic [1:0] ir,
                              output logic p2, output logic [1:0] st);
        pc = 2'd2; ir = 2'd1; p2 = 1'b1;
        if (m_mode[d] == M_ACTIVE && !halt) begin
            if (branch_taken)      pc = 2'd3;
            else if (jump)         pc = 2'd0;
            else if (stall)        ir = (m_debt[d] > 0) ? 2'd1 : 2'd2;
            else begin
                pc = 2'd1; p2 = 1'b0;
                ir = (m_debt[d] > 0) ? 2'd1 : 2'd0;
            end
        end
        if (m_mode[d] == M_IDLE)      st = 2'd0;
        else if (m_mode[d] == M_HALT) st = 2'd3;
        else                          st = (m_debt[d] > 0) ? 2'd2 : 2'd1;
    endtask

    task automatic model_advance(input int d, input logic [1:0] pc, input logic [1:0] ir);
        if (m_mode[d] == M_ACTIVE) begin
            if (pc == 2'd2 && m_stc[d] < cnt_max[d]) m_stc[d]++;
            if (ir == 2'd1 && m_bbc[d] < cnt_max[d]) m_bbc[d]++;
            if (halt) begin
                m_mode[d] = M_HALT;
                m_debt[d] = 0;
            end else if (branch_taken || jump) begin
                m_debt[d] = flush_n[d] - 1;
            end else if (!stall && m_debt[d] > 0) begin
                m_debt[d]--;
            end
        end else if (start && !(m_mode[d] == M_HALT && halt)) begin
            m_mode[d] = M_ACTIVE;
            m_debt[d] = 0;
        end
    endtask

    task automatic step(input logic s, input logic h, input logic b, input logic j, input logic t,
                        input string tag, output logic [1:0] o_pc, output logic [1:0] o_ir,
                        output logic o_p2, output logic [1:0] o_st, output logic o_bb);
        logic [1:0] epc, eir, est, apc, air, ast;
        logic       ep2, ap2, abb;
        @(posedge clk);
        #1;
        start = s; halt = h; branch_taken = b; jump = j; stall = t;
        #3;
        for (int d = 0; d < 2; d++) begin
            model_eval(d, epc, eir, ep2, est);
            apc = (d == 0) ? pc_sel_a  : pc_sel_b;
            air = (d == 0) ? ir_sel_a  : ir_sel_b;
            ap2 = (d == 0) ? pc2_sel_a : pc2_sel_b;
            ast = (d == 0) ? state_o_a : state_o_b;
            abb = (d == 0) ? bubble_a  : bubble_b;
            check($sformatf("%s dut%0d pc_sel", tag, d), 64'(apc), 64'(epc));
            check($sformatf("%s dut%0d ir_sel", tag, d), 64'(air), 64'(eir));
            check($sformatf("%s dut%0d pc2_sel", tag, d), 64'(ap2), 64'(ep2));
            check($sformatf("%s dut%0d state_o", tag, d), 64'(ast), 64'(est));
            check($sformatf("%s dut%0d bubble", tag, d), 64'(abb), 64'(eir == 2'd1));
`ifdef FETCH_PERF_CNT_EN
            check($sformatf("%s dut%0d stall_count", tag, d),
                  (d == 0) ? 64'(stall_count_a) : 64'(stall_count_b), 64'(m_stc[d]));
            check($sformatf("%s dut%0d bubble_count", tag, d),
                  (d == 0) ? 64'(bubble_count_a) : 64'(bubble_count_b), 64'(m_bbc[d]));
`endif
            model_advance(d, epc, eir);
        end
        o_pc = pc_sel_a; o_ir = ir_sel_a; o_p2 = pc2_sel_a; o_st = state_o_a; o_bb = bubble_a;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " pc_sel"},  64'(pc_sel_a),  64'd2);
        check({tag, " ir_sel"},  64'(ir_sel_a),  64'd1);
        check({tag, " pc2_sel"}, 64'(pc2_sel_a), 64'd1);
        check({tag, " bubble"},  64'(bubble_a),  64'd1);
        check({tag, " state_o"}, 64'(state_o_a), 64'd0);
        check({tag, " dutb state_o"}, 64'(state_o_b), 64'd0);
    endtask

    typedef struct {
        logic       s, h, b, j, t;
        logic [1:0] pc, ir;
        logic       p2;
        logic [1:0] st;
    } vec_t;

    function automatic vec_t v(input logic s, input logic h, input logic b, input logic j,
                               input logic t, input logic [1:0] pc, input logic [1:0] ir,
                               input logic p2, input logic [1:0] st);
        vec_t r;
        r.s = s; r.h = h; r.b = b; r.j = j; r.t = t;
        r.pc = pc; r.ir = ir; r.p2 = p2; r.st = st;
        return r;
    endfunction

    initial begin
        vec_t       tbl[$];
        logic [1:0] g_pc, g_ir, g_st;
        logic       g_p2, g_bb;

        //          s  h  b  j  t   pc ir p2 st
        tbl.push_back(v(0, 0, 0, 0, 0, 2, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 2, 1, 1, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 0, 0, 3, 1, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 2));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 0, 0, 3, 1, 1, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, 1, 2));
        tbl.push_back(v(0, 0, 0, 0, 1, 2, 1, 1, 2));
        tbl.push_back(v(0, 0, 0, 0, 1, 2, 1, 1, 2));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 2));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 1, 1, 3, 1, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 2));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 0, 1, 0, 0, 3, 1, 1, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 2, 1, 1, 2));
        tbl.push_back(v(0, 0, 0, 0, 0, 2, 1, 1, 3));
        tbl.push_back(v(0, 0, 1, 1, 1, 2, 1, 1, 3));
        tbl.push_back(v(1, 1, 0, 0, 0, 2, 1, 1, 3));
        tbl.push_back(v(1, 0, 0, 0, 0, 2, 1, 1, 3));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 1, 2, 2, 1, 1));
        tbl.push_back(v(0, 1, 1, 0, 0, 2, 1, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 2, 1, 1, 3));
        tbl.push_back(v(1, 0, 0, 0, 0, 2, 1, 1, 3));
        tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 1));

        model_reset();
        #12;
        check_idle_outputs("in_reset");
`ifdef FETCH_PERF_CNT_EN
        check("in_reset stall_count", 64'(stall_count_a), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].s, tbl[i].h, tbl[i].b, tbl[i].j, tbl[i].t, $sformatf("vec%0d", i),
                 g_pc, g_ir, g_p2, g_st, g_bb);
            check($sformatf("tbl%0d pc_sel", i),  64'(g_pc), 64'(tbl[i].pc));
            check($sformatf("tbl%0d ir_sel", i),  64'(g_ir), 64'(tbl[i].ir));
            check($sformatf("tbl%0d pc2_sel", i), 64'(g_p2), 64'(tbl[i].p2));
            check($sformatf("tbl%0d state_o", i), 64'(g_st), 64'(tbl[i].st));
            check($sformatf("tbl%0d bubble", i),  64'(g_bb), 64'(tbl[i].ir == 2'd1));
        end

        // Reset landing mid-FLUSH must abort at once and leave no bubble debt.
        step(0, 0, 1, 0, 0, "pre_rst", g_pc, g_ir, g_p2, g_st, g_bb);
        @(posedge clk);
        #1;
        start = 0; halt = 0; branch_taken = 0; jump = 0; stall = 0;
        check("mid_flush state before reset", 64'(state_o_a), 64'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_flush_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, "post_rst0", g_pc, g_ir, g_p2, g_st, g_bb);
        step(1, 0, 0, 0, 0, "post_rst1", g_pc, g_ir, g_p2, g_st, g_bb);
        step(0, 0, 0, 0, 0, "post_rst2", g_pc, g_ir, g_p2, g_st, g_bb);
        check("post_rst fetch ir_sel", 64'(g_ir), 64'd0);
        check("post_rst fetch state_o", 64'(g_st), 64'd1);

`ifdef FETCH_PERF_CNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0, "perf_start", g_pc, g_ir, g_p2, g_st, g_bb);
        for (int i = 0; i < 20; i++)
            step(0, 0, 0, 0, 1, $sformatf("perf_stall%0d", i), g_pc, g_ir, g_p2, g_st, g_bb);
        step(0, 0, 0, 0, 0, "perf_done", g_pc, g_ir, g_p2, g_st, g_bb);
        check("stall_count saturated", 64'(stall_count_a), 64'd15);
        check("stall_count wide", 64'(stall_count_b), 64'd20);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("stall_count after reset", 64'(stall_count_a), 64'd0);
        check("bubble_count after reset", 64'(bubble_count_b), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
`endif

        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(3) == 0), logic'($urandom_range(15) == 0),
                 logic'($urandom_range(7) == 0), logic'($urandom_range(7) == 0),
                 logic'($urandom_range(3) == 0), $sformatf("rnd%0d", i),
                 g_pc, g_ir, g_p2, g_st, g_bb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
